// File: rtl/rc_filter_pkg.sv
// Shared types and helpers for the multichannel RC filter.
// Holds the accumulator width rule, the frame FSM states, the
// saturation helpers and the reset-coefficient calculation.
package rc_filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic int acc_width(input int data_w, input int coef_w);
        return data_w + coef_w - 1;
    endfunction

    // Clamp a wide signed value to the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic signed [63:0] sat_acc(input logic signed [63:0] v, input int acc_w);
        return sat_w(v, acc_w);
    endfunction

    function automatic logic signed [63:0] sat_data(input logic signed [63:0] v, input int data_w);
        return sat_w(v, data_w);
    endfunction

    // round(2^(coef_w-1) / (1 + R*C*fs)), the discrete RC smoothing factor.
    function automatic int reset_coef(input real r, input real c, input real fs, input int coef_w);
        real one;
        real v;
        one = real'(longint'(1) << (coef_w - 1));
        v   = one / (1.0 + r * c * fs);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/rc_filter_datapath.sv
// One RC section update, evaluated for whichever channel the FSM selects.
// Ports:
//   x_i    : current input sample (signed)
//   acc_i  : channel accumulator before the update
//   coef_i : unsigned Q1.(COEF_WIDTH-1) coefficient
//   hp_i   : 0 = low-pass result, 1 = high-pass result
//   acc_o  : saturated accumulator after the update
//   res_o  : channel output sample
module rc_filter_datapath
    import rc_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH)
) (
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic signed [ACC_W-1:0]      acc_i,
    input  logic        [COEF_WIDTH-1:0] coef_i,
    input  logic                         hp_i,
    output logic signed [ACC_W-1:0]      acc_o,
    output logic signed [DATA_WIDTH-1:0] res_o
);

    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH + 2;
    localparam int SUM_W  = PROD_W + 1;

    logic signed [DATA_WIDTH-1:0] y_old;
    logic signed [DATA_WIDTH-1:0] y_new;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [DATA_WIDTH:0]   hp_diff;
    logic signed [PROD_W-1:0]     prod;
    logic signed [SUM_W-1:0]      sum;

    always_comb begin
        y_old   = DATA_WIDTH'(acc_i >>> (COEF_WIDTH - 1));
        diff    = (DATA_WIDTH + 1)'(x_i) - (DATA_WIDTH + 1)'(y_old);
        // Zero-extended coefficient keeps values >= 1.0 positive.
        prod    = signed'({1'b0, coef_i}) * diff;
        sum     = SUM_W'(acc_i) + SUM_W'(prod);
        acc_o   = ACC_W'(sat_acc(64'(sum), ACC_W));
        y_new   = DATA_WIDTH'(acc_o >>> (COEF_WIDTH - 1));
        hp_diff = (DATA_WIDTH + 1)'(x_i) - (DATA_WIDTH + 1)'(y_new);
        res_o   = hp_i ? DATA_WIDTH'(sat_data(64'(hp_diff), DATA_WIDTH)) : y_new;
    end

endmodule

// File: rtl/rc_filter_multichannel.sv
// Time-multiplexed bank of first-order RC low/high-pass sections.
// One frame per audio_clk_en: inputs are snapshotted, channels are
// processed one per clock through a shared datapath, then all outputs
// update together with a one-cycle out_valid.
// Ports:
//   clk, I_RSTn         : clock, asynchronous active-low reset
//   audio_clk_en        : frame strobe
//   in / out            : packed signed samples, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid           : pulse when out has been refreshed
//   busy                : frame in progress
//   overrun             : strobe arrived while busy (dropped)
//   cfg_we/ch/coef/hp   : per-channel coefficient and mode write port
module rc_filter_multichannel
    import rc_filter_pkg::*;
#(
    parameter int  CHANNELS    = 4,
    parameter int  DATA_WIDTH  = 16,
    parameter int  COEF_WIDTH  = 16,
    parameter int  SAMPLE_RATE = 48000,
    parameter real R           = 47000.0,
    parameter real C           = 47e-9
) (
    input  logic                                       clk,
    input  logic                                       I_RSTn,
    input  logic                                       audio_clk_en,
    input  logic [CHANNELS*DATA_WIDTH-1:0]             in,
    output logic [CHANNELS*DATA_WIDTH-1:0]             out,
    output logic                                       out_valid,
    output logic                                       busy,
    output logic                                       overrun,
    input  logic                                       cfg_we,
    input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [COEF_WIDTH-1:0]                      cfg_coef,
    input  logic                                       cfg_hp
);

    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH);
    localparam logic [COEF_WIDTH-1:0] RST_COEF =
        COEF_WIDTH'(reset_coef(R, C, real'(SAMPLE_RATE), COEF_WIDTH));

    state_e                       state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic                         snap_en;
    logic                         out_valid_q;
    logic [CHANNELS*DATA_WIDTH-1:0] out_q;

    logic signed [DATA_WIDTH-1:0] in_q   [CHANNELS];
    logic signed [ACC_W-1:0]      acc_q  [CHANNELS];
    logic signed [DATA_WIDTH-1:0] res_q  [CHANNELS];
    logic        [COEF_WIDTH-1:0] coef_q [CHANNELS];
    logic                         hp_q   [CHANNELS];

    logic signed [DATA_WIDTH-1:0] x_cur;
    logic signed [DATA_WIDTH-1:0] res_cur;
    logic signed [ACC_W-1:0]      acc_cur;
    logic signed [ACC_W-1:0]      acc_nxt;
    logic                         cfg_ok;

    assign x_cur   = in_q[ch_q];
    assign acc_cur = acc_q[ch_q];
    assign cfg_ok  = cfg_we && (int'(cfg_ch) < CHANNELS);

    rc_filter_datapath #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH)
    ) u_datapath (
        .x_i    (x_cur),
        .acc_i  (acc_cur),
        .coef_i (coef_q[ch_q]),
        .hp_i   (hp_q[ch_q]),
        .acc_o  (acc_nxt),
        .res_o  (res_cur)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        snap_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    state_d = RUN;
                    ch_d    = '0;
                    snap_en = 1'b1;
                end
            end
            RUN: begin
                if (ch_q == CH_W'(CHANNELS - 1)) begin
                    state_d = DONE;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                in_q[k]   <= '0;
                acc_q[k]  <= '0;
                res_q[k]  <= '0;
                coef_q[k] <= RST_COEF;
                hp_q[k]   <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_valid_q <= (state_q == DONE);
            if (snap_en) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    in_q[k] <= signed'(in[k*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
            if (state_q == RUN) begin
                acc_q[ch_q] <= acc_nxt;
                res_q[ch_q] <= res_cur;
            end
            if (state_q == DONE) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    out_q[k*DATA_WIDTH +: DATA_WIDTH] <= res_q[k];
                end
            end
            // The datapath reads the pre-edge value, so a write to the
            // channel being processed only takes effect next frame.
            if (cfg_ok) begin
                coef_q[cfg_ch] <= cfg_coef;
                hp_q[cfg_ch]   <= cfg_hp;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = audio_clk_en && (state_q != IDLE);

endmodule

// File: doc/rc_filter_multichannel.md
Name: rc_filter_multichannel

Overview:
Time-multiplexed, parametrised successor of the single-channel RC low-pass filter, with these additions:
- Up to CHANNELS independent first-order RC sections share one multiplier.
- Each channel has a runtime-writable coefficient and a low-pass/high-pass mode bit.
- Accumulation saturates.
Sits between the sound-generator mixers and the final audio mixer. Processes one audio frame per audio_clk_en.

Parameters:
- CHANNELS, 4, number of filter channels (1..16).
- DATA_WIDTH, 16, signed sample width.
- COEF_WIDTH, 16, unsigned coefficient width, format Q1.(COEF_WIDTH-1); 2^(COEF_WIDTH-1) = 1.0.
- SAMPLE_RATE, 48000, rate of audio_clk_en in Hz; used only for reset coefficients.
- R, 47000.0, real, Ohm; used only for reset coefficients.
- C, 47e-9, real, F; used only for reset coefficients.

Ports:
- clk  in  1  system clock.
- I_RSTn  in  1  asynchronous active-low reset.
- audio_clk_en  in  1  frame strobe, one clk wide.
- in  in  CHANNELS*DATA_WIDTH  packed signed inputs; channel k at [k*DATA_WIDTH +: DATA_WIDTH].
- out  out  CHANNELS*DATA_WIDTH  packed signed filtered outputs, same packing.
- out_valid  out  1  one-cycle pulse when all of out has updated.
- busy  out  1  high while a frame is being processed.
- overrun  out  1  one-cycle pulse when audio_clk_en arrives while busy.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  $clog2(CHANNELS) (min 1)  channel to configure.
- cfg_coef  in  COEF_WIDTH  new coefficient.
- cfg_hp  in  1  new mode: 0 = low-pass, 1 = high-pass.

Behaviour:
- Reset (async, I_RSTn low), all values hold until the first frame completes:
  - out = 0, out_valid = 0, busy = 0, overrun = 0.
  - All accumulators = 0, FSM = IDLE, channel counter = 0.
  - All modes = low-pass.
  - All coefficients = round(2^(COEF_WIDTH-1) / (1 + R*C*SAMPLE_RATE)).
- FSM states IDLE, RUN, DONE:
  - IDLE: on audio_clk_en, snapshot `in` into an input register, set channel counter to 0, go to RUN, busy = 1.
  - RUN: process the channel at the counter, one channel per cycle. After channel CHANNELS-1, go to DONE.
  - DONE: drive all out lanes from the computed results, pulse out_valid, busy = 0, go to IDLE.
  - Latency from audio_clk_en to out_valid = CHANNELS + 1 cycles. out changes only in the DONE cycle.
- audio_clk_en while busy (RUN or DONE):
  - Ignored; the frame is not queued. overrun pulses that cycle.
  - The ongoing frame is unaffected.
  - The same-cycle rule applies to the DONE cycle: the strobe is ignored and overrun pulses.
- Per-channel arithmetic:
  - Accumulator acc_k is signed, DATA_WIDTH + COEF_WIDTH - 1 bits.
  - y_k = acc_k >>> (COEF_WIDTH-1), taking DATA_WIDTH bits.
  - diff = x_k - y_k, DATA_WIDTH+1 bits signed, no overflow.
  - prod = signed'({1'b0, coef_k}) * diff.
  - acc_k <= sat(acc_k + prod), saturating to the accumulator range.
- Channel outputs:
  - Low-pass result = new y_k.
  - High-pass result = sat_DATA_WIDTH(x_k - new y_k).
- Configuration writes:
  - Accepted in any state. Written to the register file at clk edge; visible from the next cycle.
  - If a channel is written in the same cycle it is processed, the old value is used for that frame.
  - cfg_ch >= CHANNELS: write ignored.
  - A mode change does not clear the accumulator.
- Reset asserted mid-frame: everything returns to reset values immediately; no out_valid for the aborted frame.
- CHANNELS = 1: RUN lasts one cycle, latency 2.

Decomposition:
- Package rc_filter_pkg holds:
  - ACC_WIDTH function (DATA_WIDTH + COEF_WIDTH - 1).
  - State enum (IDLE, RUN, DONE).
  - Saturation functions sat_acc and sat_data.
  - Reset-coefficient function of R, C, SAMPLE_RATE, COEF_WIDTH.
- One sub-module, rc_filter_datapath: combinational diff/multiply/saturate for one channel plus the LP/HP output select. The top module holds the FSM, register files and snapshot.

Test Plan (DATA_WIDTH = 16, COEF_WIDTH = 16, CHANNELS = 4):
- Low-pass step: ch0 coef 16384 (0.5), LP; in0 = 16384 held for three frames -> out0 = 8192, 12288, 14336; out_valid exactly 5 cycles after each strobe.
- High-pass step: ch1 coef 16384, HP; in1 = 16384 held for three frames -> out1 = 8192, 4096, 2048. Other channels unaffected.
- Unity/zero coefficients: ch2 coef 32768, in2 = -1234 -> out2 = -1234 after the first frame. ch3 coef 0, any input -> out3 stays 0 (LP).
- HP saturation: ch0 coef 32768, LP, in0 = -32768 for one frame. Then coef 0, HP, in0 = 32767 -> out0 = 32767 (saturated, not wrapped).
- Overrun: strobe, then a second strobe 2 cycles later -> overrun pulses once, one out_valid only, outputs match single-frame results.
- Mid-frame reset: assert I_RSTn = 0 in cycle 2 of RUN -> out = 0, busy = 0, no out_valid. The next frame behaves as the first after reset, with default coefficient round(32768 / (1 + 0.047*0.047*48000 ... )) per the package function.
